// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: pipeline-side redirect and
// dequeue, head-of-queue outputs, and the instruction-memory req/ack port.
// The prefetch queue connects through the slave modport; the CPU/memory
// side (or a testbench) drives through the master modport.
interface instr_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport slave (
    input  redirect, redirect_pc, deq, mem_ack, mem_data,
    output valid, instr, pc, mem_req, mem_addr
  );

  modport master (
    output redirect, redirect_pc, deq, mem_ack, mem_data,
    input  valid, instr, pc, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from a multi-cycle
// instruction memory and buffers {pc, instr} pairs for the IF stage.
// A redirect flushes the buffer and restarts fetch; a response that was
// already in flight when the redirect arrived is dropped.
// Optional macro PFQ_BYPASS_EN: an ack arriving while the queue is empty is
// presented on the head outputs in the same cycle.
//
// state | meaning
// IDLE  | no request outstanding; issue one when a slot is guaranteed free
// WAIT  | request outstanding, its data will be pushed on ack
// DROP  | request outstanding but made stale by a redirect; data discarded
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk_i,
  input logic                   rst_i,
  instr_prefetch_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic          mem_req, mem_req_next;
  logic [31:0]   mem_addr, mem_addr_next;
  logic [CW-1:0] count, count_next;
  logic [CW-1:0] count_after_deq;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   redirect_pc_al;
  logic          q_deq;
  logic          ack_in_wait;
  logic          push;
  logic          bypass_hit;

  assign redirect_pc_al  = bus.redirect_pc & 32'hFFFF_FFFC;
  assign q_deq           = bus.deq && (count != '0);
  assign count_after_deq = count - CW'(q_deq);
  assign ack_in_wait     = (state == WAIT) && bus.mem_ack && !bus.redirect;

`ifdef PFQ_BYPASS_EN
  assign bypass_hit = ack_in_wait && (count == '0);
  assign bus.valid  = (count != '0) || bypass_hit;
  assign bus.instr  = (count != '0) ? instr_mem[rd_ptr] : bus.mem_data;
  assign bus.pc     = (count != '0) ? pc_mem[rd_ptr] : fetch_pc;
`else
  assign bypass_hit = 1'b0;
  assign bus.valid  = (count != '0);
  assign bus.instr  = instr_mem[rd_ptr];
  assign bus.pc     = pc_mem[rd_ptr];
`endif

  // A bypassed word that is consumed in the same cycle never enters storage.
  assign push = ack_in_wait && !(bypass_hit && bus.deq);

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = mem_addr;

  // FSM state and its registered outputs (request, address, fetch pointer).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
    end
  end

  // Next-state decode; the request address stays frozen until the ack.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    mem_req_next  = mem_req;
    mem_addr_next = mem_addr;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_next = redirect_pc_al;
        end else if (count_after_deq < CW'(DEPTH)) begin
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_pc;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          mem_req_next  = 1'b0;
          state_next    = IDLE;
          fetch_pc_next = bus.redirect ? redirect_pc_al : fetch_pc + 32'd4;
        end else if (bus.redirect) begin
          fetch_pc_next = redirect_pc_al;
          state_next    = DROP;
        end
      end
      DROP: begin
        if (bus.redirect) fetch_pc_next = redirect_pc_al;
        if (bus.mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy: redirect flush wins over push and dequeue.
  always_comb begin
    count_next = count;
    if (bus.redirect) count_next = '0;
    else if (push && !q_deq) count_next = count + CW'(1);
    else if (!push && q_deq) count_next = count - CW'(1);
  end

  // Queue pointers and occupancy counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_next;
      if (bus.redirect) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (q_deq) rd_ptr <= rd_ptr + PW'(1);
        if (push)  wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      instr_mem[wr_ptr] <= bus.mem_data;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch front-end that sits directly upstream of the pipelined CPU's IF stage.
- Issues word-aligned instruction reads to a multi-cycle instruction memory over a req/ack handshake and buffers the returned words with their PCs in a small FIFO.
- The IF stage pops the FIFO. A branch/jump redirect from the pipeline flushes the FIFO and restarts fetch at the new PC, discarding any in-flight response.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
redirect_i  input  1  pipeline redirect (taken branch / j / jr / jal)
redirect_pc_i  input  32  new fetch PC, valid when redirect_i=1
deq_i  input  1  IF stage consumes head entry
valid_o  output  1  head entry valid
instr_o  output  32  head instruction
pc_o  output  32  head instruction's PC
mem_req_o  output  1  read request to instruction memory (registered)
mem_addr_o  output  32  request address (registered, word-aligned)
mem_ack_i  input  1  read data valid; meaningful only while mem_req_o=1
mem_data_i  input  32  read data, valid with mem_ack_i

Behaviour:
- Reset (rst_i=1 at an edge): count=0, rd/wr ptr=0, fetch_pc=RESET_PC, state=IDLE, mem_req_o=0, mem_addr_o=0, valid_o=0. instr_o and pc_o are don't-care while valid_o=0. Reset overrides all other inputs, including mid-transaction.
- FSM states: IDLE, WAIT, DROP.
- IDLE:
  - If redirect_i: fetch_pc<=redirect_pc_i, stay IDLE.
  - Else if count<DEPTH (count after this cycle's dequeue): mem_req_o<=1, mem_addr_o<=fetch_pc, go to WAIT.
- WAIT (mem_req_o=1, mem_addr_o stable until ack):
  - mem_ack_i=1, no redirect: push {fetch_pc, mem_data_i}, fetch_pc<=fetch_pc+4, mem_req_o<=0, go to IDLE.
  - redirect_i=1 with mem_ack_i=1: discard the data, fetch_pc<=redirect_pc_i, mem_req_o<=0, go to IDLE.
  - redirect_i=1 without ack: fetch_pc<=redirect_pc_i, go to DROP. mem_req_o stays 1 with the old address.
- DROP: wait for mem_ack_i. On ack, discard the data, mem_req_o<=0, go to IDLE. A further redirect in DROP updates fetch_pc only.
- Redirect also flushes the queue: count<=0, rd_ptr<=wr_ptr. It takes priority over deq_i and push in the same cycle.
- Dequeue happens when valid_o & deq_i: rd_ptr advances. deq_i while valid_o=0 is ignored.
- Count rules:
  - Simultaneous push and dequeue leaves count unchanged.
  - A push is never lost: a request is issued only when a slot is guaranteed free.
- Pointers are ($clog2(DEPTH))-bit and wrap modulo DEPTH.
- fetch_pc+4 wraps modulo 2^32. mem_addr_o[1:0] is always 00; redirect_pc_i[1:0] is forced to 00.
- valid_o = (count!=0); instr_o and pc_o are driven from the head entry, combinationally from storage.
- Latency: ack in cycle N gives valid_o=1 in cycle N+1. A request rises 1 cycle after entering IDLE. Minimum fetch period is 2 cycles per word plus memory latency.
- mem_ack_i while mem_req_o=0 is ignored.

Optional Feature:
PFQ_BYPASS_EN
- Defined: when count==0, state=WAIT and mem_ack_i=1 (no redirect), valid_o=1 in the same cycle, with instr_o=mem_data_i and pc_o=fetch_pc.
  - If deq_i is also 1, the word is not written into the queue.
  - If deq_i is 0, the word is pushed normally.
- Undefined: no combinational path from mem_ack_i/mem_data_i to the outputs; first valid is the cycle after ack.

Test Plan:
- Reset then a memory with 2-cycle ack latency, deq_i=0 -> requests at addresses 0x0, 0x4, 0x8, 0xC. The queue fills to 4; mem_req_o stays 0 afterwards; pc_o=0x0 at head.
- Full queue (4 entries), deq_i=1 for one cycle -> pc_o advances to 0x4 and a new request to 0x10 is issued the next cycle. count never exceeds 4.
- Redirect to 0x40 while in WAIT for 0x8 with no ack -> FSM goes to DROP and valid_o=0 the next cycle. The late ack for 0x8 is discarded; the next request is 0x40 and the first valid pc_o is 0x40.
- Redirect to 0x80 in the same cycle as ack and deq_i -> the data is dropped, the queue is empty, and the next mem_addr_o is 0x80.
- rst_i asserted while mem_req_o=1 -> next cycle mem_req_o=0 and valid_o=0. A later ack is ignored; the first request after reset is RESET_PC.
- With PFQ_BYPASS_EN, empty queue, ack carrying data 0x2002_0005 at pc 0x0 with deq_i=1 -> same cycle valid_o=1 and instr_o=0x2002_0005; count stays 0.
